// File: rtl/ex8_reg_file_pkg.sv
// ---------------------------------------------------------------------------
// ex8_pkg: shared sizing constants and types for the ex8 register file.
//   XLEN       - width of each architectural register and of all data ports
//   NREGS      - number of architectural registers (x0..x31)
//   REG_ADDR_W - register address width
//   reg_addr_t - register index type
//   xlen_t     - register data type
// ---------------------------------------------------------------------------
package ex8_pkg;

  localparam int XLEN       = 32;
  localparam int NREGS      = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/ex8_reg_file_if.sv
// ---------------------------------------------------------------------------
// ex8_reg_file_if: operand-read / write-back bus of the register file.
//   rs1, rs2    - read addresses (master -> slave)
//   rd          - write address (master -> slave)
//   data_in     - write data (master -> slave)
//   reg_write   - write enable, active high (master -> slave)
//   read_data1  - contents of rs1 (slave -> master)
//   read_data2  - contents of rs2 (slave -> master)
// The datapath (decode/WB stages) is the master; the register file is the slave.
// ---------------------------------------------------------------------------
interface ex8_reg_file_if;
  import ex8_pkg::*;

  reg_addr_t rs1;
  reg_addr_t rs2;
  reg_addr_t rd;
  xlen_t     data_in;
  logic      reg_write;
  xlen_t     read_data1;
  xlen_t     read_data2;

  modport master (
    output rs1, rs2, rd, data_in, reg_write,
    input  read_data1, read_data2
  );

  modport slave (
    input  rs1, rs2, rd, data_in, reg_write,
    output read_data1, read_data2
  );

endinterface

// File: rtl/ex8_reg_file_read_port.sv
// ---------------------------------------------------------------------------
// ex8_read_port: one combinational read port of the register file.
//   rs_i      - read address
//   stored_i  - stored contents of register rs_i (don't care when rs_i == 0)
//   wr_en_i   - a write to a nonzero rd is being committed this cycle
//   rd_i      - write address
//   wr_data_i - write data
//   data_o    - read result
// x0 always reads zero. With EX8_REG_FILE_BYPASS_EN defined, a read of the
// register being written returns the incoming write data in the same cycle.
// ---------------------------------------------------------------------------
module ex8_read_port
  import ex8_pkg::*;
(
  input  reg_addr_t rs_i,
  input  xlen_t     stored_i,
  input  logic      wr_en_i,
  input  reg_addr_t rd_i,
  input  xlen_t     wr_data_i,
  output xlen_t     data_o
);

`ifdef EX8_REG_FILE_BYPASS_EN
  // wr_en_i already excludes rd == 0 and reset, so x0 is never forwarded.
  always_comb begin
    data_o = stored_i;
    if (rs_i == '0) begin
      data_o = '0;
    end else if (wr_en_i && (rs_i == rd_i)) begin
      data_o = wr_data_i;
    end
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{wr_en_i, rd_i, wr_data_i};

  assign data_o = (rs_i == '0) ? '0 : stored_i;
`endif

endmodule

// File: rtl/ex8_reg_file.sv
// ---------------------------------------------------------------------------
// ex8_reg_file: 32 x XLEN integer register file, two asynchronous read ports
// and one synchronous write port. x0 is hardwired to zero and has no storage.
//   clk   - system clock, all state updates on the rising edge
//   rst_n - synchronous active-low reset, clears x1..x31 (wins over a write)
//   bus   - ex8_reg_file_if.slave: rs1/rs2/rd/data_in/reg_write in,
//           read_data1/read_data2 out
// Optional feature macro: EX8_REG_FILE_BYPASS_EN (write-through forwarding
// of data_in to a read port addressing the register being written).
// ---------------------------------------------------------------------------
module ex8_reg_file
  import ex8_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  ex8_reg_file_if.slave bus
);

  // Storage exists only for x1..x31.
  xlen_t regs_q [NREGS-1:1];

  // Effective write strobe: suppressed for x0 and during reset. Shared with
  // the read ports so forwarding uses exactly the same qualification.
  logic  wr_en;
  xlen_t stored1;
  xlen_t stored2;

  assign wr_en = rst_n && bus.reg_write && (bus.rd != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[bus.rd] <= bus.data_in;
    end
  end

  // Address 0 falls outside the storage range; the read port masks it.
  always_comb begin
    stored1 = '0;
    stored2 = '0;
    if (bus.rs1 != '0) stored1 = regs_q[bus.rs1];
    if (bus.rs2 != '0) stored2 = regs_q[bus.rs2];
  end

  ex8_read_port u_rp1 (
    .rs_i      (bus.rs1),
    .stored_i  (stored1),
    .wr_en_i   (wr_en),
    .rd_i      (bus.rd),
    .wr_data_i (bus.data_in),
    .data_o    (bus.read_data1)
  );

  ex8_read_port u_rp2 (
    .rs_i      (bus.rs2),
    .stored_i  (stored2),
    .wr_en_i   (wr_en),
    .rd_i      (bus.rd),
    .wr_data_i (bus.data_in),
    .data_o    (bus.read_data2)
  );

endmodule

// File: tb/tb_ex8_reg_file.sv
// ---------------------------------------------------------------------------
// tb_ex8_reg_file: directed self-checking bench for ex8_reg_file.
// Inputs change 1 time unit after a rising edge; read ports are sampled 1
// time unit after that, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_ex8_reg_file;
  import ex8_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  ex8_reg_file_if bus ();

  ex8_reg_file dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.reg_write = 1'b0;
    bus.rd        = '0;
    bus.data_in   = '0;
  endtask

  task automatic write_reg(input reg_addr_t a, input xlen_t d);
    bus.reg_write = 1'b1;
    bus.rd        = a;
    bus.data_in   = d;
    tick();
    idle();
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.rs1 = '0;
    bus.rs2 = '0;
    idle();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NREGS; i++) begin
      bus.rs1 = reg_addr_t'(i);
      bus.rs2 = reg_addr_t'(NREGS - 1 - i);
      #1;
      checks++;
      if (bus.read_data1 !== 32'd0) begin
        errors++;
        $display("FAIL reset_rd1 x%0d: got %h expected 00000000", i, bus.read_data1);
      end
      checks++;
      if (bus.read_data2 !== 32'd0) begin
        errors++;
        $display("FAIL reset_rd2 x%0d: got %h expected 00000000", NREGS - 1 - i, bus.read_data2);
      end
    end
  endtask

  task automatic test_basic_write;
    write_reg(5'd1, 32'd15);
    bus.rs1 = 5'd1;
    bus.rs2 = 5'd1;
    #1;
    checks++;
    if (bus.read_data1 !== 32'd15) begin
      errors++;
      $display("FAIL basic_rd1: got %0d expected 15", bus.read_data1);
    end
    checks++;
    if (bus.read_data2 !== 32'd15) begin
      errors++;
      $display("FAIL basic_rd2: got %0d expected 15", bus.read_data2);
    end
  endtask

  task automatic test_back_to_back;
    bus.reg_write = 1'b1;
    bus.rd = 5'd11; bus.data_in = 32'd12; tick();
    bus.rd = 5'd12; bus.data_in = 32'd10; tick();
    bus.rd = 5'd13; bus.data_in = 32'd9;  tick();
    idle();
    bus.rs1 = 5'd11;
    bus.rs2 = 5'd12;
    #1;
    checks++;
    if (bus.read_data1 !== 32'd12) begin
      errors++;
      $display("FAIL seq_x11: got %0d expected 12", bus.read_data1);
    end
    checks++;
    if (bus.read_data2 !== 32'd10) begin
      errors++;
      $display("FAIL seq_x12: got %0d expected 10", bus.read_data2);
    end
    bus.rs1 = 5'd13;
    bus.rs2 = 5'd1;
    #1;
    checks++;
    if (bus.read_data1 !== 32'd9) begin
      errors++;
      $display("FAIL seq_x13: got %0d expected 9", bus.read_data1);
    end
    checks++;
    if (bus.read_data2 !== 32'd15) begin
      errors++;
      $display("FAIL seq_x1_kept: got %0d expected 15", bus.read_data2);
    end
  endtask

  task automatic test_x0_protect;
    write_reg(5'd0, 32'hDEADBEEF);
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd1;
    #1;
    checks++;
    if (bus.read_data1 !== 32'd0) begin
      errors++;
      $display("FAIL x0_write: got %h expected 00000000", bus.read_data1);
    end
    checks++;
    if (bus.read_data2 !== 32'd15) begin
      errors++;
      $display("FAIL x0_no_alias_x1: got %h expected 0000000f", bus.read_data2);
    end
  endtask

  task automatic test_write_disable;
    bus.reg_write = 1'b0;
    bus.rd        = 5'd5;
    bus.data_in   = 32'd7;
    tick();
    idle();
    bus.rs1 = 5'd5;
    #1;
    checks++;
    if (bus.read_data1 !== 32'd0) begin
      errors++;
      $display("FAIL wdis_x5: got %0d expected 0", bus.read_data1);
    end
  endtask

  task automatic test_reset_priority;
    rst_n         = 1'b0;
    bus.reg_write = 1'b1;
    bus.rd        = 5'd5;
    bus.data_in   = 32'd7;
    tick();
    rst_n = 1'b1;
    idle();
    bus.rs1 = 5'd5;
    bus.rs2 = 5'd1;
    #1;
    checks++;
    if (bus.read_data1 !== 32'd0) begin
      errors++;
      $display("FAIL rstpri_x5: got %0d expected 0", bus.read_data1);
    end
    checks++;
    if (bus.read_data2 !== 32'd0) begin
      errors++;
      $display("FAIL rstpri_x1: got %0d expected 0", bus.read_data2);
    end
    bus.rs1 = 5'd11;
    bus.rs2 = 5'd13;
    #1;
    checks++;
    if (bus.read_data1 !== 32'd0) begin
      errors++;
      $display("FAIL rstpri_x11: got %0d expected 0", bus.read_data1);
    end
    checks++;
    if (bus.read_data2 !== 32'd0) begin
      errors++;
      $display("FAIL rstpri_x13: got %0d expected 0", bus.read_data2);
    end
  endtask

  task automatic test_same_cycle;
    xlen_t exp_pre;
`ifdef EX8_REG_FILE_BYPASS_EN
    exp_pre = 32'd99;
`else
    exp_pre = 32'd0;
`endif
    bus.rs1       = 5'd20;
    bus.rs2       = 5'd21;
    bus.reg_write = 1'b1;
    bus.rd        = 5'd20;
    bus.data_in   = 32'd99;
    #1;
    checks++;
    if (bus.read_data1 !== exp_pre) begin
      errors++;
      $display("FAIL same_cycle_pre: got %0d expected %0d", bus.read_data1, exp_pre);
    end
    checks++;
    if (bus.read_data2 !== 32'd0) begin
      errors++;
      $display("FAIL same_cycle_other_port: got %0d expected 0", bus.read_data2);
    end
    tick();
    idle();
    #1;
    checks++;
    if (bus.read_data1 !== 32'd99) begin
      errors++;
      $display("FAIL same_cycle_post: got %0d expected 99", bus.read_data1);
    end
    // rd = 0 must never be forwarded onto a read of x0.
    bus.rs1       = 5'd0;
    bus.reg_write = 1'b1;
    bus.rd        = 5'd0;
    bus.data_in   = 32'd55;
    #1;
    checks++;
    if (bus.read_data1 !== 32'd0) begin
      errors++;
      $display("FAIL x0_no_forward: got %0d expected 0", bus.read_data1);
    end
    tick();
    idle();
    // Overwrite of a live register on consecutive edges.
    bus.rs1 = 5'd20;
    bus.rs2 = 5'd20;
    write_reg(5'd20, 32'hFFFF_FFFF);
    write_reg(5'd20, 32'h8000_0001);
    #1;
    checks++;
    if (bus.read_data1 !== 32'h8000_0001) begin
      errors++;
      $display("FAIL overwrite_rd1: got %h expected 80000001", bus.read_data1);
    end
    checks++;
    if (bus.read_data2 !== 32'h8000_0001) begin
      errors++;
      $display("FAIL overwrite_rd2: got %h expected 80000001", bus.read_data2);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus.rs1 = '0;
    bus.rs2 = '0;
    idle();
    test_reset();
    test_basic_write();
    test_back_to_back();
    test_x0_protect();
    test_write_disable();
    test_reset_priority();
    test_same_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
